// File: rtl/max_pool_2x2_if.sv
// Stream bundle for max_pool_2x2: one 6-channel pixel beat in, one pooled beat out.
// The pooler is the slave; whoever feeds pixels and consumes results is the master.
interface max_pool_2x2_if;
    logic              i_features_valid;
    logic signed [7:0] i_features_in  [0:5];
    logic              o_features_valid;
    logic signed [7:0] o_features_out [0:5];
    logic              o_frame_done;

    modport master (
        output i_features_valid,
        output i_features_in,
        input  o_features_valid,
        input  o_features_out,
        input  o_frame_done
    );

    modport slave (
        input  i_features_valid,
        input  i_features_in,
        output o_features_valid,
        output o_features_out,
        output o_frame_done
    );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-order 6-channel feature stream.
// Even rows fold column pairs into a line buffer; odd rows complete each window.
module max_pool_2x2 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic          i_clk,
    input  logic          i_rst,
    max_pool_2x2_if.slave feat
);
    // state  | meaning
    // S_FILL | even row: pair maxima written into the line buffer
    // S_POOL | odd row: pair max merged with line buffer entry, result emitted
    typedef enum logic {S_FILL = 1'b0, S_POOL = 1'b1} state_t;

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    generate
        if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_width
            $error("max_pool_2x2: IMG_W must be even and >= 2");
        end
        if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_height
            $error("max_pool_2x2: IMG_H must be even and >= 2");
        end
    endgenerate

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic signed [7:0] hold     [0:5];
    logic signed [7:0] linebuf  [0:IMG_W/2-1][0:5];
    logic signed [7:0] max_pair [0:5];
    logic signed [7:0] max_quad [0:5];
    logic signed [7:0] out_data [0:5];
    logic              out_valid;
    logic              frame_done;
    logic              col_odd;
    logic              col_last;
    logic              row_last;
    logic              lb_we;
    logic [LW-1:0]     lb_idx;

    assign col_odd  = col[0];
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign lb_idx   = LW'(col >> 1);
    assign lb_we    = ~i_rst & feat.i_features_valid & col_odd & (state == S_FILL);

    // Operands are declared signed, so these compares are two's-complement.
    always_comb begin
        for (int c = 0; c < 6; c++) begin
            max_pair[c] = (feat.i_features_in[c] > hold[c]) ? feat.i_features_in[c] : hold[c];
            max_quad[c] = (linebuf[lb_idx][c] > max_pair[c]) ? linebuf[lb_idx][c] : max_pair[c];
        end
    end

    // No reset: every entry is rewritten on the even row before the odd row reads it.
    always_ff @(posedge i_clk) begin
        if (lb_we) begin
            for (int c = 0; c < 6; c++) begin
                linebuf[lb_idx][c] <= max_pair[c];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_FILL;
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int c = 0; c < 6; c++) begin
                hold[c]     <= '0;
                out_data[c] <= '0;
            end
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (feat.i_features_valid) begin
                if (!col_odd) begin
                    for (int c = 0; c < 6; c++) begin
                        hold[c] <= feat.i_features_in[c];
                    end
                end else if (state == S_POOL) begin
                    for (int c = 0; c < 6; c++) begin
                        out_data[c] <= max_quad[c];
                    end
                    out_valid  <= 1'b1;
                    frame_done <= row_last & col_last;
                end

                if (col_last) begin
                    col   <= '0;
                    row   <= row_last ? '0 : row + 1'b1;
                    state <= (state == S_FILL) ? S_POOL : S_FILL;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign feat.o_features_valid = out_valid;
    assign feat.o_frame_done     = frame_done;
    generate
        for (genvar c = 0; c < 6; c++) begin : g_out
            assign feat.o_features_out[c] = out_data[c];
        end
    endgenerate

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: a 4x4 instance for hand-checked vectors and
// a default 28x28 instance compared against a behavioural pooling model.
module tb_max_pool_2x2;
    logic i_clk = 1'b0;
    logic i_rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    max_pool_2x2_if sif ();
    max_pool_2x2_if bif ();

    max_pool_2x2 #(.IMG_W(4), .IMG_H(4)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .feat  (sif)
    );

    max_pool_2x2 big (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .feat  (bif)
    );

    // ch1 carries the signed corner cases; the quads give -5, 127, 127, -128.
    localparam logic signed [7:0] CH1 [0:15] = '{
        8'(-128), 8'(-5),   8'(-1),   8'(0),
        8'(-7),   8'(-100), 8'(-128), 8'(127),
        8'(127),  8'(-128), 8'(-128), 8'(-128),
        8'(-128), 8'(-128), 8'(-128), 8'(-128)};

    // Expected pooled beats, ch0 in the top byte.
    localparam logic [47:0] EXP1 [0:3] = '{
        {8'(5),  8'(-5),   8'(0),   8'(1),  8'(14), 8'(-1)},
        {8'(7),  8'(127),  8'(-2),  8'(3),  8'(16), 8'(-3)},
        {8'(13), 8'(127),  8'(-8),  8'(9),  8'(22), 8'(-9)},
        {8'(15), 8'(-128), 8'(-10), 8'(11), 8'(24), 8'(-11)}};
    localparam logic [47:0] EXP2 [0:3] = '{
        {8'(6),  8'(-4),   8'(1),   8'(2),  8'(15), 8'(0)},
        {8'(8),  8'(1),    8'(-1),  8'(4),  8'(17), 8'(-2)},
        {8'(14), 8'(-127), 8'(-7),  8'(10), 8'(23), 8'(-8)},
        {8'(16), 8'(-127), 8'(-9),  8'(12), 8'(25), 8'(-10)}};

    int          s_cyc [$];
    logic [47:0] s_dat [$];
    logic        s_done [$];
    int          s_orphan = 0;
    logic [47:0] b_dat [$];
    logic        b_done [$];
    int          b_orphan = 0;
    int          comp_cyc [$];
    logic signed [7:0] big_px [0:27][0:27][0:5];

    function automatic logic [47:0] pack(input logic signed [7:0] a [0:5]);
        return {a[0], a[1], a[2], a[3], a[4], a[5]};
    endfunction

    function automatic logic signed [7:0] smax(input logic signed [7:0] a, input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [7:0] pix(input int idx, input int c, input int off);
        int r;
        int k;
        logic signed [7:0] v;
        r = idx / 4;
        k = idx % 4;
        case (c)
            0:       v = 8'(idx);
            1:       v = CH1[idx];
            2:       v = 8'(-idx);
            3:       v = ((r % 2 == 0) && (k % 2 == 1)) ? 8'(idx) : 8'(-50);
            4:       v = ((r % 2 == 1) && (k % 2 == 0)) ? 8'(10 + idx) : 8'(0);
            default: v = ((r % 2 == 0) && (k % 2 == 0)) ? 8'(-idx - 1) : 8'(-100);
        endcase
        return v + 8'(off);
    endfunction

    always @(negedge i_clk) begin
        if (sif.o_features_valid === 1'b1) begin
            s_cyc.push_back(cyc);
            s_dat.push_back(pack(sif.o_features_out));
            s_done.push_back(sif.o_frame_done);
        end else if (sif.o_frame_done !== 1'b0) begin
            s_orphan++;
        end
        if (bif.o_features_valid === 1'b1) begin
            b_dat.push_back(pack(bif.o_features_out));
            b_done.push_back(bif.o_frame_done);
        end else if (bif.o_frame_done !== 1'b0) begin
            b_orphan++;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            sif.i_features_valid = 1'b0;
        end
    endtask

    task automatic clear_mon;
        s_cyc.delete();
        s_dat.delete();
        s_done.delete();
        comp_cyc.delete();
        s_orphan = 0;
    endtask

    task automatic send_beat(input int idx, input int off);
        @(negedge i_clk);
        sif.i_features_valid = 1'b1;
        for (int c = 0; c < 6; c++) sif.i_features_in[c] = pix(idx, c, off);
        if ((idx == 5) || (idx == 7) || (idx == 13) || (idx == 15)) comp_cyc.push_back(cyc);
    endtask

    task automatic send_frame(input int off, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) idle(1 + $urandom_range(0, 2));
            send_beat(i, off);
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        sif.i_features_valid = 1'b1;
        bif.i_features_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sif.i_features_in[c] = 8'sd99;
            bif.i_features_in[c] = 8'sd99;
        end
        repeat (3) @(negedge i_clk);
        total++;
        if (sif.o_features_valid !== 1'b0 || sif.o_frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: valid=%b done=%b, want 0 0", sif.o_features_valid, sif.o_frame_done);
        end
        total++;
        if (pack(sif.o_features_out) !== 48'h0) begin
            bad++;
            $display("FAIL reset_out: got %h want 0", pack(sif.o_features_out));
        end
        total++;
        if (bif.o_features_valid !== 1'b0 || pack(bif.o_features_out) !== 48'h0) begin
            bad++;
            $display("FAIL reset_big: valid=%b out=%h, want 0 0", bif.o_features_valid, pack(bif.o_features_out));
        end
        i_rst = 1'b0;
        sif.i_features_valid = 1'b0;
        bif.i_features_valid = 1'b0;
        idle(2);
        total++;
        if (s_dat.size() != 0) begin
            bad++;
            $display("FAIL reset_no_output: got %0d beats want 0", s_dat.size());
        end
    endtask

    task automatic test_basic(input bit gaps, input string tag);
        clear_mon();
        send_frame(0, gaps);
        idle(3);
        total++;
        if (s_dat.size() != 4 || comp_cyc.size() != 4) begin
            bad++;
            $display("FAIL %s_count: got %0d beats want 4", tag, s_dat.size());
        end
        for (int k = 0; k < 4 && k < s_dat.size() && k < comp_cyc.size(); k++) begin
            total++;
            if (s_dat[k] !== EXP1[k]) begin
                bad++;
                $display("FAIL %s_data[%0d]: got %h want %h", tag, k, s_dat[k], EXP1[k]);
            end
            total++;
            if (s_cyc[k] != comp_cyc[k] + 1) begin
                bad++;
                $display("FAIL %s_latency[%0d]: got cycle %0d want %0d", tag, k, s_cyc[k], comp_cyc[k] + 1);
            end
            total++;
            if (s_done[k] !== (k == 3)) begin
                bad++;
                $display("FAIL %s_done[%0d]: got %b want %b", tag, k, s_done[k], (k == 3));
            end
        end
        total++;
        if (s_orphan != 0) begin
            bad++;
            $display("FAIL %s_orphan_done: got %0d want 0", tag, s_orphan);
        end
        total++;
        if (sif.o_features_valid !== 1'b0 || pack(sif.o_features_out) !== EXP1[3]) begin
            bad++;
            $display("FAIL %s_hold: valid=%b out=%h, want 0 %h", tag, sif.o_features_valid,
                     pack(sif.o_features_out), EXP1[3]);
        end
    endtask

    task automatic test_back_to_back;
        logic [47:0] want;
        clear_mon();
        send_frame(0, 1'b0);
        send_frame(1, 1'b0);
        idle(3);
        total++;
        if (s_dat.size() != 8 || comp_cyc.size() != 8) begin
            bad++;
            $display("FAIL b2b_count: got %0d beats want 8", s_dat.size());
        end
        for (int k = 0; k < 8 && k < s_dat.size() && k < comp_cyc.size(); k++) begin
            want = (k < 4) ? EXP1[k] : EXP2[k - 4];
            total++;
            if (s_dat[k] !== want) begin
                bad++;
                $display("FAIL b2b_data[%0d]: got %h want %h", k, s_dat[k], want);
            end
            total++;
            if (s_cyc[k] != comp_cyc[k] + 1) begin
                bad++;
                $display("FAIL b2b_latency[%0d]: got cycle %0d want %0d", k, s_cyc[k], comp_cyc[k] + 1);
            end
            total++;
            if (s_done[k] !== ((k % 4) == 3)) begin
                bad++;
                $display("FAIL b2b_done[%0d]: got %b want %b", k, s_done[k], ((k % 4) == 3));
            end
        end
        total++;
        if (s_orphan != 0) begin
            bad++;
            $display("FAIL b2b_orphan_done: got %0d want 0", s_orphan);
        end
    endtask

    task automatic test_mid_reset;
        for (int i = 0; i < 9; i++) send_beat(i, 0);
        @(negedge i_clk);
        i_rst = 1'b1;
        sif.i_features_valid = 1'b1;
        for (int c = 0; c < 6; c++) sif.i_features_in[c] = pix(9, c, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        sif.i_features_valid = 1'b0;
        idle(1);
        clear_mon();
        send_frame(0, 1'b0);
        idle(3);
        total++;
        if (s_dat.size() != 4) begin
            bad++;
            $display("FAIL midrst_count: got %0d beats want 4", s_dat.size());
        end
        for (int k = 0; k < 4 && k < s_dat.size(); k++) begin
            total++;
            if (s_dat[k] !== EXP1[k] || s_done[k] !== (k == 3)) begin
                bad++;
                $display("FAIL midrst_beat[%0d]: got %h done=%b want %h done=%b", k, s_dat[k], s_done[k],
                         EXP1[k], (k == 3));
            end
        end
    endtask

    task automatic test_big;
        logic [47:0] want;
        int          r2;
        int          c2;
        int          ndone;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                for (int ch = 0; ch < 6; ch++) big_px[r][c][ch] = 8'($urandom);
        b_dat.delete();
        b_done.delete();
        b_orphan = 0;
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                @(negedge i_clk);
                bif.i_features_valid = 1'b1;
                for (int ch = 0; ch < 6; ch++) bif.i_features_in[ch] = big_px[r][c][ch];
            end
        end
        @(negedge i_clk);
        bif.i_features_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        total++;
        if (b_dat.size() != 196) begin
            bad++;
            $display("FAIL big_count: got %0d beats want 196", b_dat.size());
        end
        ndone = 0;
        for (int k = 0; k < 196 && k < b_dat.size(); k++) begin
            r2 = 2 * (k / 14);
            c2 = 2 * (k % 14);
            for (int ch = 0; ch < 6; ch++)
                want[47 - 8*ch -: 8] = smax(smax(big_px[r2][c2][ch], big_px[r2][c2+1][ch]),
                                            smax(big_px[r2+1][c2][ch], big_px[r2+1][c2+1][ch]));
            total++;
            if (b_dat[k] !== want) begin
                bad++;
                $display("FAIL big_data[%0d]: got %h want %h", k, b_dat[k], want);
            end
            if (b_done[k] === 1'b1) ndone++;
        end
        total++;
        if (ndone != 1 || b_orphan != 0 || b_dat.size() != 196 || b_done[195] !== 1'b1) begin
            bad++;
            $display("FAIL big_frame_done: got %0d pulses (%0d stray) want 1 on the last beat", ndone, b_orphan);
        end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0, "basic");
        test_basic(1'b1, "gaps");
        test_back_to_back();
        test_mid_reset();
        test_big();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
